// File: rtl/rv_pkg.sv
// Shared RISC-V core constants: datapath width, reset PC, canonical NOP and the base opcodes
// that the main decoder matches on instr[6:0].
package rv_pkg;
  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [6:0] {
    OPC_R    = 7'b0110011,
    OPC_I    = 7'b0010011,
    OPC_LOAD = 7'b0000011,
    OPC_S    = 7'b0100011,
    OPC_B    = 7'b1100011,
    OPC_U    = 7'b0110111,
    OPC_J    = 7'b1101111
  } opcode_e;
endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch channel: valid/ready request, in-order response with no backpressure.
interface if_stage_if #(parameter int XLEN = rv_pkg::XLEN);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/fetch_buf.sv
// Synchronous FIFO of fetched {instr, pc} entries; head visible combinationally, zero added latency.
// Flush empties it in one cycle and wins over push/pop; caller must never push when full.
module fetch_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/if_stage.sv
// Fetch stage + IF/ID register: 1 cycle from imem_rsp_valid to id_valid; stall holds IF/ID and
// throttles requests once in-flight plus buffered reaches BUF_DEPTH. IF_PERF_CNT_EN adds a bubble counter.
module if_stage
  import rv_pkg::*;
#(
  parameter int              XLEN      = rv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
  parameter int              BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  if_stage_if.master       imem,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             stall,
  output logic             id_valid,
  output logic [31:0]      id_instr,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_pc_plus4
`ifdef IF_PERF_CNT_EN
  , output logic [31:0]    perf_bubble_cnt
`endif
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_ent_t;

  logic [XLEN-1:0] pc_q, rsp_pc_q, redir_pc;
  logic [CW-1:0]   outstanding_q, drop_cnt_q, buf_count;
  logic [CW:0]     occupancy;
  logic            buf_empty, accept, rsp_keep, bypass, push, pop;
  fetch_ent_t      rsp_ent, head_ent, load_ent;

  assign redir_pc  = redirect_pc & ~XLEN'(3);
  assign occupancy = {1'b0, outstanding_q} + {1'b0, buf_count};

  assign imem.imem_req_valid = !rst && (occupancy < (CW+1)'(BUF_DEPTH)) && !redirect_valid;
  assign imem.imem_req_addr  = pc_q;
  assign accept              = imem.imem_req_valid && imem.imem_req_ready;

  // Responses owed to a flushed stream are counted off by drop_cnt_q and never tagged.
  assign rsp_keep = imem.imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign bypass   = rsp_keep && buf_empty && !stall;
  assign push     = rsp_keep && !bypass;
  assign pop      = !buf_empty && !stall && !redirect_valid;

  assign rsp_ent  = '{instr: imem.imem_rsp_data, pc: rsp_pc_q};
  assign load_ent = buf_empty ? rsp_ent : head_ent;

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .W     ($bits(fetch_ent_t))
  ) u_fetch_buf (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_valid),
    .push     (push),
    .push_dat (rsp_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .count    (buf_count),
    .empty    (buf_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      id_valid      <= 1'b0;
      id_instr      <= NOP_INSTR;
      id_pc         <= '0;
      id_pc_plus4   <= '0;
    end else begin
      outstanding_q <= outstanding_q + CW'(accept) - CW'(imem.imem_rsp_valid);
      if (redirect_valid) begin
        pc_q       <= redir_pc;
        rsp_pc_q   <= redir_pc;
        drop_cnt_q <= outstanding_q - CW'(imem.imem_rsp_valid);
        id_valid   <= 1'b0;
        id_instr   <= NOP_INSTR;
      end else begin
        if (accept)   pc_q     <= pc_q + XLEN'(4);
        if (rsp_keep) rsp_pc_q <= rsp_pc_q + XLEN'(4);
        if (imem.imem_rsp_valid && (drop_cnt_q != '0)) drop_cnt_q <= drop_cnt_q - 1'b1;
        if (!stall) begin
          if (!buf_empty || bypass) begin
            id_valid    <= 1'b1;
            id_instr    <= load_ent.instr;
            id_pc       <= load_ent.pc;
            id_pc_plus4 <= load_ent.pc + XLEN'(4);
          end else begin
            id_valid <= 1'b0;
            id_instr <= NOP_INSTR;
          end
        end
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubble_cnt <= '0;
    end else if (!stall && !redirect_valid && buf_empty && !bypass && (perf_bubble_cnt != '1)) begin
      perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_if_stage.sv
// Randomised fetch-stage bench: the expected decode stream is the sequential PC walk, restarted
// at every redirect or reset; a monitor pops it whenever decode accepts an instruction.
module tb_if_stage;
  import rv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          NCYC   = 2700;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, stall;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
`endif

  always #5 clk = ~clk;

  if_stage_if #(.XLEN(32)) imem ();

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4)
`ifdef IF_PERF_CNT_EN
    , .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  logic [31:0] redir_tgt, gap_addr, stall_pc;
  bit          want_redir_addr = 0, want_reset_addr = 0, after_rst = 0, lat_checked = 0;
  int          cycle = 0, checks = 0, passed = 0, consumed = 0, first_acc = -1;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'h1234_5677;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
  endtask

  // Stimulus + memory model
  initial begin
    bit rnd;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0;
    imem.imem_req_ready = 1'b0; imem.imem_rsp_valid = 1'b0; imem.imem_rsp_data = '0;
    gen_pc = RST_PC;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      cycle++;
      rnd = (cycle > 60 && cycle <= 2000) || (cycle > 2102 && cycle <= 2600);
      rst = (cycle <= 2) || (cycle == 2101) || (cycle == 2102);
      imem.imem_req_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cycle >= 41 && cycle <= 45);
      stall = rnd ? ($urandom_range(0, 3) == 0) : (cycle >= 25 && cycle <= 27);
      redirect_valid = !rst && ((rnd && $urandom_range(0, 29) == 0) || cycle == 2001);
      redirect_pc = (cycle == 2001) ? 32'hFFFF_FFF2 : $urandom();
      if (rst) begin
        exp_q.delete();
        pend_q.delete();
        gen_pc = RST_PC;
        want_reset_addr = 1;
        want_redir_addr = 0;
      end else if (redirect_valid) begin
        exp_q.delete();
        gen_pc = redirect_pc & 32'hFFFF_FFFC;
        redir_tgt = gen_pc;
        want_redir_addr = 1;
        want_reset_addr = 0;
      end
      while (exp_q.size() < 8) begin
        exp_q.push_back(gen_pc);
        gen_pc = gen_pc + 32'd4;
      end
      imem.imem_rsp_valid = 1'b0;
      if (!rst && pend_q.size() > 0 && pend_q[0].due <= cycle && (!rnd || $urandom_range(0, 2) != 0)) begin
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = instr_of(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
      #1;
      if (imem.imem_req_valid && imem.imem_req_ready) begin
        pend_q.push_back('{addr: imem.imem_req_addr, due: cycle + 1 + (rnd ? $urandom_range(0, 2) : 0)});
        if (first_acc < 0 && cycle > 2) first_acc = cycle;
      end
    end
    @(negedge clk);
    #3;
    checks++;
    if (consumed >= 300) passed++;
    else $display("FAIL liveness: consumed %0d instructions, required at least 300", consumed);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Monitor / scoreboard
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        after_rst = 1;
        chk("req_valid_in_reset", {31'd0, imem.imem_req_valid}, 32'd0);
      end else begin
        if (after_rst) begin
          chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
          chk("rst_id_instr", id_instr, NOP_INSTR);
          chk("rst_id_pc", id_pc, 32'd0);
          chk("rst_id_pc_plus4", id_pc_plus4, 32'd0);
          after_rst = 0;
        end
        if (redirect_valid) begin
          chk("no_req_on_redirect", {31'd0, imem.imem_req_valid}, 32'd0);
        end else if (imem.imem_req_valid) begin
          if (want_redir_addr) begin
            chk("first_addr_after_redirect", imem.imem_req_addr, redir_tgt);
            want_redir_addr = 0;
          end
          if (want_reset_addr) begin
            chk("first_addr_after_reset", imem.imem_req_addr, RST_PC);
            want_reset_addr = 0;
          end
        end
        if (!lat_checked && id_valid && first_acc > 0) begin
          chk("fetch_to_decode_latency", cycle - first_acc, 32'd2);
          lat_checked = 1;
        end
        if (cycle == 25) stall_pc = id_pc;
        if (cycle == 27) begin
          chk("stall_holds_id_pc", id_pc, stall_pc);
          chk("stall_throttles_req", {31'd0, imem.imem_req_valid}, 32'd0);
        end
        if (cycle == 41) gap_addr = imem.imem_req_addr;
        if (cycle == 45) begin
          chk("gap_pc_holds", imem.imem_req_addr, gap_addr);
          chk("gap_id_valid", {31'd0, id_valid}, 32'd0);
        end
        if (!id_valid) begin
          chk("nop_when_invalid", id_instr, NOP_INSTR);
        end else if (!stall && !redirect_valid) begin
          e = exp_q.pop_front();
          chk("id_pc", id_pc, e);
          chk("id_instr", id_instr, instr_of(e));
          chk("id_pc_plus4", id_pc_plus4, e + 32'd4);
          consumed++;
        end
      end
    end
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction fetch stage plus IF/ID pipeline register of the RISC-V core. Owns the PC and issues in-order word fetches to instruction memory over a valid/ready request channel. Buffers returned words and presents {instr, pc} to the decode stage, where the main decoder consumes instr[6:0]. Handles redirect from branch/jal resolution and stall from the hazard unit.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
BUF_DEPTH, 2, max fetches in flight plus buffered (power of 2, >=2)

Ports:
clk  in  1  core clock
rst  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts request this cycle
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response word valid (in order, >=1 cycle after accept)
imem_rsp_data  in  32  fetched instruction
redirect_valid  in  1  taken branch/jal; flush and refetch
redirect_pc  in  XLEN  redirect target
stall  in  1  hold IF/ID contents (decode not accepting)
id_valid  out  1  IF/ID holds a real instruction
id_instr  out  32  instruction to decode; NOP when !id_valid
id_pc  out  XLEN  PC of id_instr
id_pc_plus4  out  XLEN  id_pc + 4 (jal link value)

Behaviour:
- Clock clk; reset rst is synchronous and active-high. Both fixed.
- Reset: pc_q=RESET_PC, imem_req_valid=0 for the reset cycle, id_valid=0, id_instr=32'h0000_0013, id_pc=0, id_pc_plus4=0. Buffer, outstanding count and drop count are all cleared.
- Reset asserted mid-operation wins over everything. In-flight responses after reset deassertion are not tracked; the memory must also be reset.
- Request: imem_req_valid=!rst && (outstanding+buf_count < BUF_DEPTH) && !redirect_valid. imem_req_addr=pc_q.
- On accept (valid&&ready): pc_q+=4, wrapping modulo 2^XLEN. outstanding increments.
- Response: when imem_rsp_valid, outstanding decrements.
  - If drop_cnt>0: discard the word and decrement drop_cnt.
  - Else push {data, pc} into the buffer. The buffer PC comes from a shadow counter advanced per push.
- IF/ID load, when !stall: id_valid<=buf nonempty, id_instr<=head instr (else NOP), id_pc/id_pc_plus4<=head pc/pc+4. Pop on load.
- Bypass: a response arriving with the buffer empty and !stall loads IF/ID in the same cycle. Fetch-to-decode latency is 1 cycle after rsp_valid.
- Stall: IF/ID and buffer head hold. Fetching continues until the occupancy limit is reached.
- id_instr is forced to 32'h0000_0013 whenever id_valid=0. This is required because decode treats unknown opcodes as RegWrite=1.
- Redirect (priority over stall, and over accept/response in the same cycle):
  - pc_q<=redirect_pc. The buffer is flushed.
  - drop_cnt<=outstanding, including a response arriving that same cycle, which is dropped.
  - id_valid<=0 and id_instr<=NOP.
  - No request is issued in the redirect cycle. The first new request goes out the following cycle.
- redirect_pc[1:0]!=0: bits [1:0] are forced to 0. No trap.
- Simultaneous push and pop keep buf_count unchanged. Overflow cannot occur, by the issue rule.

Optional Feature:
IF_PERF_CNT_EN:
- Defined: adds output perf_bubble_cnt[31:0]. It increments each cycle where !stall && !redirect_valid && the buffer and bypass are both empty (a decode bubble). It resets to 0 and saturates at 32'hFFFF_FFFF.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package rv_pkg: XLEN, RESET_PC default, NOP_INSTR=32'h0000_0013, opcode constants (R/I/B/S/U/J/LOAD).
- Sub-module fetch_buf: parameterised BUF_DEPTH synchronous FIFO of {instr, pc}, with a flush input and count output.

Test Plan:
- Reset release, imem 1-cycle latency, always ready -> requests at 0x0,0x4,0x8; id_pc=0x0 with id_valid=1 two cycles after first accept, then one instruction per cycle.
- imem_req_ready=0 for 5 cycles -> pc_q holds 0x4, id_valid=0 and id_instr=0x00000013 during the gap; no duplicate or skipped PCs afterwards.
- stall=1 for 3 cycles with id_pc=0x8 -> id_pc holds 0x8, imem_req_valid drops once 2 requests are outstanding/buffered; after release, 0xC then 0x10 follow in order.
- redirect_valid with redirect_pc=0x100 while 2 fetches are in flight -> both responses dropped, next request addr=0x100, next id_pc=0x100, id_pc_plus4=0x104.
- redirect on the same cycle as stall and imem_rsp_valid -> redirect wins: response dropped, id_valid=0 next cycle.
- pc_q=0xFFFF_FFFC accepted -> next request addr=0x0000_0000; rst asserted mid-stream -> next cycle id_valid=0, next request addr=RESET_PC.
